// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: ID/EX/MEM hazard inputs and pipeline control outputs of pipeline_ctrl
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic id_valid;
  logic [7:0] id_ctrl;
  logic [1:0] id_re;
  logic [3:0] id_rd;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic ex_br_taken;
  logic mem_busy;
  logic stall_fe;
  logic bubble_ex;
  logic flush_ifid;
  logic stall_be;
  logic halted;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_valid, id_ctrl, id_re, id_rd, id_rs, id_rt, ex_br_taken, mem_busy,
    input stall_fe, bubble_ex, flush_ifid, stall_be, halted, stall_cnt
  );
  modport slave (
    input id_valid, id_ctrl, id_re, id_rd, id_rs, id_rt, ex_br_taken, mem_busy,
    output stall_fe, bubble_ex, flush_ifid, stall_be, halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use stall, branch flush, memory freeze and halt-drain sequencing for a 5-stage pipeline
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_t state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic ex_v, ex_ld;
  logic [3:0] ex_rd;
  logic lu, fe, bub, fl, be, hl;
  logic [CNT_W-1:0] cnt;
  logic unused;
  assign unused = ^{bus.id_ctrl[7:5], bus.id_ctrl[3:1]};
  assign lu = ex_v & ex_ld & (ex_rd != 4'd0) & bus.id_valid &
              ((bus.id_re[0] & (bus.id_rs == ex_rd)) | (bus.id_re[1] & (bus.id_rt == ex_rd)));
  always_comb begin
    state_nx = state;
    dcnt_nx = dcnt;
    fe = 1'b0;
    bub = 1'b0;
    fl = 1'b0;
    be = 1'b0;
    hl = 1'b0;
    case (state)
      RUN:
        if (bus.mem_busy) begin
          fe = 1'b1;
          be = 1'b1;
        end else if (bus.ex_br_taken) begin
          fl = 1'b1;
          bub = 1'b1;
        end else if (lu) begin
          fe = 1'b1;
          bub = 1'b1;
        end else if (bus.id_valid & bus.id_ctrl[0]) begin
          fe = 1'b1;
          state_nx = DRAIN;
          dcnt_nx = DW'(DRAIN_CYCLES - 1);
        end
      DRAIN: begin
        fe = 1'b1;
        fl = 1'b1;
        be = bus.mem_busy;
        // halted rises in the cycle the HLT retires from WB
        if (!bus.mem_busy) begin
          if (dcnt == '0) begin
            hl = 1'b1;
            state_nx = HALTED;
          end else dcnt_nx = dcnt - 1'b1;
        end
      end
      default: begin
        hl = 1'b1;
        fe = 1'b1;
        be = 1'b1;
        bub = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      dcnt <= '0;
      ex_v <= 1'b0;
      ex_ld <= 1'b0;
      ex_rd <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      dcnt <= dcnt_nx;
      if (!be) begin
        ex_v <= bus.id_valid & ~bub;
        ex_ld <= bus.id_ctrl[4];
        ex_rd <= bus.id_rd;
      end
      if (fe && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
  assign bus.stall_fe = fe;
  assign bus.bubble_ex = bub;
  assign bus.flush_ifid = fl;
  assign bus.stall_be = be;
  assign bus.halted = hl;
  assign bus.stall_cnt = cnt;
endmodule
